// File: rtl/display7_decoder.sv
// Receive side of a 7-segment link: synchronises an active-low segment bus,
// debounces it with a stability window and decodes it to a hex digit.
module display7_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEnable,
  input  logic [6:0]       iSegments,
  output logic [3:0]       oDigit,
  output logic             oValid,
  output logic             oBlank,
  output logic             oInvalid,
  output logic             oChange,
  output logic [ERR_W-1:0] oErrCount
);

  localparam logic [7:0]       STABLE_CNT = 8'(STABLE_CYCLES);
  localparam logic [6:0]       SEG_BLANK  = 7'h7F;
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("display7_decoder: STABLE_CYCLES out of range 1..255");
  end

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_VALID   = 2'd1,
    ST_BLANK   = 2'd2,
    ST_INVALID = 2'd3
  } state_t;

  logic [6:0]       r_sync1;
  logic [6:0]       r_sync2;
  logic [6:0]       r_cand;
  logic [7:0]       r_cnt;
  logic [6:0]       r_accepted;
  state_t           r_state;

  logic [6:0]       w_cand_next;
  logic [7:0]       w_cnt_next;
  logic             w_window_done;
  logic             w_accept;
  logic [3:0]       w_dec_digit;
  logic             w_dec_legal;
  state_t           w_state_next;
  logic [3:0]       w_digit_next;
  logic [ERR_W-1:0] w_err_next;

  // Two-flop synchroniser; free-running so the bus is always tracked.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sync1 <= SEG_BLANK;
      r_sync2 <= SEG_BLANK;
    end else begin
      r_sync1 <= iSegments;
      r_sync2 <= r_sync1;
    end
  end

  // Stability window: a new sample restarts the window at 1, and the
  // window completes on the edge where the count reaches STABLE_CNT.
  always_comb begin
    w_cand_next   = r_cand;
    w_cnt_next    = r_cnt;
    w_window_done = 1'b0;
    if (iEnable) begin
      if (r_sync2 != r_cand) begin
        w_cand_next   = r_sync2;
        w_cnt_next    = 8'd1;
        w_window_done = (STABLE_CNT == 8'd1);
      end else if (r_cnt < STABLE_CNT) begin
        w_cnt_next    = r_cnt + 8'd1;
        w_window_done = ((r_cnt + 8'd1) == STABLE_CNT);
      end
    end
  end

  assign w_accept = w_window_done &&
                    ((r_state == ST_EMPTY) || (w_cand_next != r_accepted));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cand     <= SEG_BLANK;
      r_cnt      <= 8'd0;
      r_accepted <= SEG_BLANK;
    end else begin
      r_cand <= w_cand_next;
      r_cnt  <= w_cnt_next;
      if (w_accept) begin
        r_accepted <= w_cand_next;
      end
    end
  end

  // Segment order in the literals is g..a, active low.
  always_comb begin
    w_dec_digit = 4'h0;
    w_dec_legal = 1'b1;
    case (w_cand_next)
      7'b1000000: w_dec_digit = 4'h0;
      7'b1111001: w_dec_digit = 4'h1;
      7'b0100100: w_dec_digit = 4'h2;
      7'b0110000: w_dec_digit = 4'h3;
      7'b0011001: w_dec_digit = 4'h4;
      7'b0010010: w_dec_digit = 4'h5;
      7'b0000010: w_dec_digit = 4'h6;
      7'b1111000: w_dec_digit = 4'h7;
      7'b0000000: w_dec_digit = 4'h8;
      7'b0011000: w_dec_digit = 4'h9;
      7'b0001000: w_dec_digit = 4'hA;
      7'b0000011: w_dec_digit = 4'hB;
      7'b1000110: w_dec_digit = 4'hC;
      7'b0100001: w_dec_digit = 4'hD;
      7'b0000110: w_dec_digit = 4'hE;
      7'b0001110: w_dec_digit = 4'hF;
      default:    w_dec_legal = 1'b0;
    endcase
  end

  // Classification FSM; EMPTY is left on the first acceptance and only
  // reset brings it back.
  always_comb begin
    w_state_next = r_state;
    w_digit_next = oDigit;
    w_err_next   = oErrCount;
    if (w_accept) begin
      if (w_dec_legal) begin
        w_state_next = ST_VALID;
        w_digit_next = w_dec_digit;
      end else if (w_cand_next == SEG_BLANK) begin
        w_state_next = ST_BLANK;
      end else begin
        w_state_next = ST_INVALID;
        if (oErrCount != ERR_MAX) begin
          w_err_next = oErrCount + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state   <= ST_EMPTY;
      oDigit    <= 4'h0;
      oValid    <= 1'b0;
      oBlank    <= 1'b0;
      oInvalid  <= 1'b0;
      oChange   <= 1'b0;
      oErrCount <= '0;
    end else begin
      r_state   <= w_state_next;
      oDigit    <= w_digit_next;
      oValid    <= (w_state_next == ST_VALID);
      oBlank    <= (w_state_next == ST_BLANK);
      oInvalid  <= (w_state_next == ST_INVALID);
      oChange   <= w_accept;
      oErrCount <= w_err_next;
    end
  end

endmodule

// File: tb/tb_display7_decoder.sv
// Bench for display7_decoder: directed scenarios plus random segment traffic,
// checked by a reference model feeding an expected-response queue.
module tb_display7_decoder;

  localparam int STABLE = 4;
  localparam int ERR_W  = 8;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic             iEnable = 1'b0;
  logic [6:0]       iSegments = 7'h7F;
  logic [3:0]       oDigit;
  logic             oValid;
  logic             oBlank;
  logic             oInvalid;
  logic             oChange;
  logic [ERR_W-1:0] oErrCount;

  display7_decoder #(.STABLE_CYCLES(STABLE), .ERR_W(ERR_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iEnable(iEnable), .iSegments(iSegments),
    .oDigit(oDigit), .oValid(oValid), .oBlank(oBlank), .oInvalid(oInvalid),
    .oChange(oChange), .oErrCount(oErrCount)
  );

  // clock / reset
  always #5 iClk = ~iClk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_change = 0;

  logic [14:0] exp_q[$];  // {digit, valid, blank, invalid, err}

  logic [6:0] code_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: tracks the bus two samples late and the run length of
  // identical samples, then applies the decode rules on acceptance
  logic [6:0] m_s1 = 7'h7F, m_s2 = 7'h7F, m_cand = 7'h7F, m_acc = 7'h7F;
  int         m_run = 0;
  bit         m_have = 0;
  logic [3:0] m_digit = 4'h0;
  logic       m_v = 0, m_b = 0, m_i = 0;
  int         m_err = 0;

  function automatic int lookup(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (code_tab[k] == p) return k;
    return -1;
  endfunction

  function automatic logic [14:0] m_pack();
    return {m_digit, m_v, m_b, m_i, 8'(m_err)};
  endfunction

  task automatic model_step();
    logic [6:0] seg_s;
    bit done;
    int idx;
    seg_s = m_s2;
    m_s2 = m_s1;
    m_s1 = iSegments;
    if (!iEnable) return;
    done = 0;
    if (seg_s != m_cand) begin
      m_cand = seg_s;
      m_run = 1;
      done = (STABLE == 1);
    end else if (m_run < STABLE) begin
      m_run++;
      done = (m_run == STABLE);
    end
    if (done && (!m_have || m_cand != m_acc)) begin
      m_have = 1;
      m_acc = m_cand;
      idx = lookup(m_cand);
      m_v = (idx >= 0);
      m_b = (idx < 0) && (m_cand == 7'h7F);
      m_i = (idx < 0) && (m_cand != 7'h7F);
      if (idx >= 0) m_digit = 4'(idx);
      if (m_i && m_err < (1 << ERR_W) - 1) m_err++;
      exp_q.push_back(m_pack());
    end
  endtask

  initial forever begin
    @(posedge iClk or negedge iRst_n);
    if (!iRst_n) begin
      m_s1 = 7'h7F; m_s2 = 7'h7F; m_cand = 7'h7F; m_acc = 7'h7F;
      m_run = 0; m_have = 0; m_digit = 4'h0;
      m_v = 0; m_b = 0; m_i = 0; m_err = 0;
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // monitor: compares held outputs every cycle and pops on each oChange
  initial forever begin
    @(negedge iClk);
    if (iRst_n) begin
      check("held_outputs", {oDigit, oValid, oBlank, oInvalid, oErrCount}, m_pack());
      if (oChange) begin
        n_change++;
        if (exp_q.size() == 0) check("unexpected_change", oChange, 1'b0);
        else check("change_resp", {oDigit, oValid, oBlank, oInvalid, oErrCount}, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        check("missed_change", oChange, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic wait_change(input int budget, output int edges);
    int e;
    e = 0;
    edges = -1;
    while (e < budget) begin
      @(posedge iClk);
      #1;
      e++;
      if (oChange) begin
        edges = e;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e, c0, pick;

    iRst_n = 1'b0; iEnable = 1'b1; iSegments = 7'h7F;
    cycles(3);
    check("reset_outputs", {oDigit, oValid, oBlank, oInvalid, oChange, oErrCount}, 0);

    // first acceptance and its latency
    @(negedge iClk);
    iRst_n = 1'b1;
    iSegments = 7'b0110000;
    wait_change(12, e);
    check("latency_first", e, 2 + STABLE);
    check("first_digit", {oDigit, oValid}, {4'h3, 1'b1});
    cycles(4);

    // sweep all legal codes
    c0 = n_change;
    for (int i = 0; i < 16; i++) begin
      iSegments = code_tab[i];
      cycles(8);
      check("sweep_digit", {oDigit, oValid, oBlank, oInvalid}, {4'(i), 3'b100});
    end
    check("sweep_pulses", n_change - c0, 16);

    // short glitch of 8 between two holds of 5
    iSegments = code_tab[5];
    cycles(8);
    c0 = n_change;
    iSegments = 7'b0000000;
    cycles(3);
    iSegments = code_tab[5];
    cycles(10);
    check("glitch_pulses", n_change - c0, 0);
    check("glitch_digit", oDigit, 4'h5);

    // blank, then illegal patterns up to counter saturation
    iSegments = 7'h7F;
    cycles(8);
    check("blank_flags", {oDigit, oValid, oBlank, oInvalid}, {4'h5, 3'b010});
    iSegments = 7'b1110111;
    cycles(8);
    check("invalid_flags", {oValid, oBlank, oInvalid, oErrCount}, {3'b001, 8'd1});
    for (int k = 0; k < 10; k++) begin
      iSegments = (k % 2 == 0) ? 7'b1101111 : 7'b1110111;
      cycles(6);
    end
    check("err_count_11", oErrCount, 8'd11);
    for (int k = 10; k < 300; k++) begin
      iSegments = (k % 2 == 0) ? 7'b1101111 : 7'b1110111;
      cycles(6);
    end
    check("err_saturated", oErrCount, 8'd255);

    // enable dropped two stable cycles into a window
    iSegments = code_tab[7];
    cycles(4);
    iEnable = 1'b0;
    c0 = n_change;
    cycles(20);
    check("disabled_pulses", n_change - c0, 0);
    check("disabled_hold", {oInvalid, oErrCount}, {1'b1, 8'd255});
    iEnable = 1'b1;
    wait_change(10, e);
    check("reenable_latency", e, 2);
    check("reenable_digit", {oDigit, oValid}, {4'h7, 1'b1});

    // async reset in the middle of a window
    iSegments = code_tab[9];
    cycles(8);
    check("pre_reset_digit", oDigit, 4'h9);
    iSegments = code_tab[10];
    cycles(3);
    #2;
    iRst_n = 1'b0;
    #1;
    check("async_reset", {oDigit, oValid, oBlank, oInvalid, oChange, oErrCount}, 0);
    @(negedge iClk);
    iSegments = code_tab[9];
    @(negedge iClk);
    iRst_n = 1'b1;
    wait_change(12, e);
    check("latency_after_reset", e, 2 + STABLE);
    check("digit_after_reset", {oDigit, oValid}, {4'h9, 1'b1});

    // random traffic
    for (int r = 0; r < 400; r++) begin
      pick = $urandom_range(0, 9);
      if (pick < 6) iSegments = code_tab[$urandom_range(0, 15)];
      else if (pick < 8) iSegments = 7'h7F;
      else iSegments = 7'($urandom_range(0, 127));
      iEnable = ($urandom_range(0, 9) != 0);
      cycles($urandom_range(1, 8));
    end
    iEnable = 1'b1;
    cycles(12);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/display7_decoder.md
Name: display7_decoder

Overview:
- Receive side of the 7-segment interface: samples an active-low 7-segment pattern (bit0=a … bit6=g) and recovers the hex digit it encodes.
- Used for loopback self-test of the counter display path and for reading segment buses driven by external boards.
- Synchronises the input and filters glitches with a stability window. Reports a valid digit, a blank display, or an illegal pattern, and counts illegal patterns.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a pattern is accepted (legal range 1..255).
- ERR_W, 8, width of the saturating illegal-pattern counter.

Ports:
- iClk  input  1  system clock.
- iRst_n  input  1  asynchronous active-low reset.
- iEnable  input  1  sampling enable; low freezes all state.
- iSegments  input  7  active-low segment lines, bit0=a … bit6=g.
- oDigit  output  4  last accepted legal digit.
- oValid  output  1  accepted pattern is a legal digit.
- oBlank  output  1  accepted pattern is 7'b1111111 (all segments off).
- oInvalid  output  1  accepted pattern is neither a legal digit nor blank.
- oChange  output  1  one-cycle pulse when a new pattern is accepted.
- oErrCount  output  ERR_W  saturating count of illegal acceptances.

Behaviour:
- Reset (async, iRst_n=0):
  - oDigit=0, oValid=0, oBlank=0, oInvalid=0, oChange=0, oErrCount=0.
  - Sync flops = 7'h7F, candidate = 7'h7F, stability counter = 0, accepted register = 7'h7F, state = EMPTY.
  - Reset asserted mid-window discards the partial window.
- Synchroniser: iSegments passes through 2 flops (seg_s). These flops always run, independent of iEnable.
- Stability filter, evaluated each cycle with iEnable=1:
  - seg_s != candidate: candidate <= seg_s; counter <= 1.
  - seg_s == candidate and counter < STABLE_CYCLES: counter increments.
  - counter == STABLE_CYCLES: counter holds.
- Acceptance:
  - Fires on the edge where the counter becomes STABLE_CYCLES. This includes the load edge when STABLE_CYCLES=1.
  - Fires only if state=EMPTY or candidate != accepted register.
  - On acceptance: accepted <= candidate, outputs update and oChange=1 for exactly that cycle.
- Latency: a pattern held on iSegments is reflected on the outputs 2+STABLE_CYCLES rising edges after it first appears (6 with defaults).
- Glitches:
  - Any pattern held fewer than STABLE_CYCLES synchronised cycles is never accepted.
  - Returning to the already-accepted pattern produces no oChange.
- Decode table (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- States (one-hot outputs oValid/oBlank/oInvalid; all zero in EMPTY):
  - EMPTY → any acceptance leaves EMPTY; EMPTY is re-entered only by reset.
  - VALID: legal code; oDigit <= decoded value.
  - BLANK: pattern 1111111; oDigit holds its previous value.
  - INVALID: any other code; oDigit holds; oErrCount += 1, saturating at 2^ERR_W−1.
  - Any of VALID/BLANK/INVALID transitions to any other on acceptance of a different pattern.
- iEnable=0:
  - Candidate, counter, state and outputs hold; oChange=0.
  - Re-enabling resumes counting from the held counter value.
- Simultaneous events: an input change on the cycle acceptance would occur restarts the window. No acceptance, no pulse.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset then hold iSegments=7'b0110000 for 10 cycles → at edge 6: oDigit=3, oValid=1, oChange pulse of 1 cycle; no further pulses.
- Sweep all 16 legal codes, each held 8 cycles → oDigit follows 0..F, oValid=1 throughout after first acceptance, exactly 16 oChange pulses.
- Accepted 5 (0010010), inject 7'b0000000 for 3 cycles, return to 5 → no acceptance of 8, no oChange, oDigit stays 5.
- Hold 7'b1111111 → oBlank=1, oValid=0, oDigit unchanged. Then hold 7'b1110111 → oInvalid=1, oErrCount=1. Alternate illegal 7'b1110111 / 7'b1101111, 300 times → oErrCount saturates at 255.
- Drop iEnable after 2 stable cycles of code 7, hold 20 cycles, raise again → acceptance occurs 2 enabled cycles later (oDigit=7); no oChange while disabled.
- Assert iRst_n low mid-window with oDigit=9 → all outputs 0 immediately (async). After release, same pattern is accepted again with oChange, after 2+STABLE_CYCLES edges.
